// File: rtl/lbm_pkg.sv
// Shared definitions for the D2Q9 lattice-Boltzmann streaming engine.
// Direction order: 0=C0, 1=N, 2=NE, 3=E, 4=SE, 5=S, 6=SW, 7=W, 8=NW.
// N is y-1 (towards the top row), E is x+1.
package lbm_pkg;

  localparam int NUM_DIRS = 9;

  typedef enum logic [3:0] {
    DIR_C0 = 4'd0,
    DIR_N  = 4'd1,
    DIR_NE = 4'd2,
    DIR_E  = 4'd3,
    DIR_SE = 4'd4,
    DIR_S  = 4'd5,
    DIR_SW = 4'd6,
    DIR_W  = 4'd7,
    DIR_NW = 4'd8
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Lattice velocity components, indexed by direction.
  localparam int DX [NUM_DIRS] = '{0, 0, 1, 1, 1, 0, -1, -1, -1};
  localparam int DY [NUM_DIRS] = '{0, -1, -1, 0, 1, 1, 1, 0, -1};

  // Opposite direction, used to reverse populations on barrier cells.
  function automatic int opp(input int d);
    case (d)
      DIR_C0:  return DIR_C0;
      DIR_N:   return DIR_S;
      DIR_NE:  return DIR_SW;
      DIR_E:   return DIR_W;
      DIR_SE:  return DIR_NW;
      DIR_S:   return DIR_N;
      DIR_SW:  return DIR_NE;
      DIR_W:   return DIR_E;
      DIR_NW:  return DIR_SE;
      default: return DIR_C0;
    endcase
  endfunction

endpackage

// File: rtl/lbm_nbr_addr.sv
// Per-direction neighbour address generator for the streaming engine.
// Takes the registered cell coordinates and linear address and produces, for
// every direction, the destination address plus an in-grid flag.
// Destination addresses are formed by adding constant offsets to the cell
// address; edge detection compares x/y against constants only.
// Optional build macro PERIODIC_X_EN: wrap the E/W edges instead of
// suppressing writes that leave the grid horizontally (y edges always clip).
import lbm_pkg::*;

module lbm_nbr_addr #(
  parameter int GRID_W = 64,
  parameter int GRID_H = 32,
  parameter int ADDR_W = $clog2(GRID_W * GRID_H),
  parameter int XW     = $clog2(GRID_W),
  parameter int YW     = $clog2(GRID_H)
) (
  input  logic [XW-1:0]                x_i,
  input  logic [YW-1:0]                y_i,
  input  logic [ADDR_W-1:0]            addr_i,
  output logic [NUM_DIRS*ADDR_W-1:0]   dest_addr_o,
  output logic [NUM_DIRS-1:0]          dest_valid_o
);

  localparam logic [XW-1:0]     X_MAX  = XW'(GRID_W - 1);
  localparam logic [YW-1:0]     Y_MAX  = YW'(GRID_H - 1);
  localparam logic [ADDR_W-1:0] ROW_SZ = ADDR_W'(GRID_W);

  genvar gi;
  for (gi = 0; gi < NUM_DIRS; gi++) begin : g_dir
    localparam int DXI = DX[gi];
    localparam int DYI = DY[gi];
    // Two's-complement offset; the sum is reduced modulo 2^ADDR_W, which is
    // exact because every in-grid destination fits in ADDR_W bits.
    localparam logic [ADDR_W-1:0] OFS = ADDR_W'(DYI * GRID_W + DXI);

    logic              x_lo_out;
    logic              x_hi_out;
    logic              y_out;
    logic [ADDR_W-1:0] wrap_adj;

    assign x_lo_out = (DXI < 0) && (x_i == '0);
    assign x_hi_out = (DXI > 0) && (x_i == X_MAX);
    assign y_out    = ((DYI < 0) && (y_i == '0)) || ((DYI > 0) && (y_i == Y_MAX));

`ifdef PERIODIC_X_EN
    // Leaving on the west side lands in the last column of the same row
    // (+GRID_W), leaving east lands in column 0 (-GRID_W).
    assign wrap_adj         = x_lo_out ? ROW_SZ : (x_hi_out ? (-ROW_SZ) : '0);
    assign dest_valid_o[gi] = ~y_out;
`else
    assign wrap_adj         = '0;
    assign dest_valid_o[gi] = ~(y_out | x_lo_out | x_hi_out);
`endif

    assign dest_addr_o[gi*ADDR_W +: ADDR_W] = addr_i + OFS + wrap_adj;
  end

endmodule

// File: rtl/lbm_stream_engine.sv
// D2Q9 lattice-Boltzmann streaming engine with fused full-way bounce-back.
// One cell per clock: read address issued at t, bank data returns at t+1,
// registered per-direction writes appear at t+2. The source buffer is
// selected by bank_sel_o; writes go to the other buffer and bank_sel_o
// toggles when a pass completes.
// Optional build macro PERIODIC_X_EN (handled in lbm_nbr_addr): periodic
// E/W boundaries.
import lbm_pkg::*;

module lbm_stream_engine #(
  parameter int GRID_W = 64,
  parameter int GRID_H = 32,
  parameter int DATA_W = 16,
  parameter int ADDR_W = $clog2(GRID_W * GRID_H)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         bank_sel_o,
  output logic [31:0]                  step_count_o,
  output logic [ADDR_W-1:0]            rd_addr_o,
  input  logic [NUM_DIRS*DATA_W-1:0]   rd_data_i,
  input  logic                         rd_barrier_i,
  output logic [NUM_DIRS-1:0]          wr_en_o,
  output logic [NUM_DIRS*ADDR_W-1:0]   wr_addr_o,
  output logic [NUM_DIRS*DATA_W-1:0]   wr_data_o
);

  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);

  // ---------------- control FSM ----------------
  state_e state_q, state_d;
  logic   drain_q, drain_d;
  logic   issue;       // a read address is presented this cycle
  logic   finish;      // last drain cycle: pass bookkeeping updates
  logic   last_cell;

  // Raster position of the read currently being issued.
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [ADDR_W-1:0] addr_q;

  assign last_cell = (x_q == X_MAX) && (y_q == Y_MAX);

  // State register and drain-cycle flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Next-state logic; DRAIN lasts two cycles so the last read reaches the write stage.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    issue   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        issue = 1'b1;
        if (last_cell) begin
          state_d = ST_DRAIN;
          drain_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (drain_q) begin
          state_d = ST_DONE;
          drain_d = 1'b0;
          finish  = 1'b1;
        end else begin
          drain_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done_o = (state_q == ST_DONE);

  // Buffer select and pass counter advance together on entry to DONE.
  logic        bank_q;
  logic [31:0] step_q;

  // Ping-pong bank select and completed-pass counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q <= 1'b0;
      step_q <= '0;
    end else if (finish) begin
      bank_q <= ~bank_q;
      step_q <= step_q + 32'd1;
    end
  end

  assign bank_sel_o   = bank_q;
  assign step_count_o = step_q;

  // Raster counters: x wraps at the last column, everything clears after the last cell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else if (issue) begin
      if (last_cell) begin
        x_q    <= '0;
        y_q    <= '0;
        addr_q <= '0;
      end else if (x_q == X_MAX) begin
        x_q    <= '0;
        y_q    <= y_q + YW'(1);
        addr_q <= addr_q + ADDR_W'(1);
      end else begin
        x_q    <= x_q + XW'(1);
        addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

  assign rd_addr_o = addr_q;

  // ---------------- pipeline stage 1: aligned with returning read data ----------------
  logic              s1_valid_q;
  logic [XW-1:0]     s1_x_q;
  logic [YW-1:0]     s1_y_q;
  logic [ADDR_W-1:0] s1_addr_q;

  // Delay the issued coordinates by one cycle to match the RAM read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_addr_q  <= '0;
    end else begin
      s1_valid_q <= issue;
      s1_x_q     <= x_q;
      s1_y_q     <= y_q;
      s1_addr_q  <= addr_q;
    end
  end

  logic [NUM_DIRS*ADDR_W-1:0] nbr_addr;
  logic [NUM_DIRS-1:0]        nbr_valid;

  lbm_nbr_addr #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .ADDR_W (ADDR_W),
    .XW     (XW),
    .YW     (YW)
  ) u_nbr_addr (
    .x_i          (s1_x_q),
    .y_i          (s1_y_q),
    .addr_i       (s1_addr_q),
    .dest_addr_o  (nbr_addr),
    .dest_valid_o (nbr_valid)
  );

  // Write mux: on a barrier cell slot k carries the opposite population,
  // which then streams along c_k (full-way bounce-back fused with streaming).
  logic [NUM_DIRS*DATA_W-1:0] wr_data_d;

  genvar gi;
  for (gi = 0; gi < NUM_DIRS; gi++) begin : g_mux
    localparam int OPP = opp(gi);
    assign wr_data_d[gi*DATA_W +: DATA_W] = rd_barrier_i ? rd_data_i[OPP*DATA_W +: DATA_W]
                                                         : rd_data_i[gi*DATA_W +: DATA_W];
  end

  // ---------------- pipeline stage 2: registered write port ----------------
  logic [NUM_DIRS-1:0]        wr_en_q;
  logic [NUM_DIRS*ADDR_W-1:0] wr_addr_q;
  logic [NUM_DIRS*DATA_W-1:0] wr_data_q;

  // Register per-direction writes; out-of-grid destinations are masked off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= s1_valid_q ? nbr_valid : '0;
      if (s1_valid_q) begin
        wr_addr_q <= nbr_addr;
        wr_data_q <= wr_data_d;
      end
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;

endmodule

// File: tb/tb_lbm_stream_engine.sv
// Self-checking bench for lbm_stream_engine on a 4x4 grid.
// A bench-side RAM pair feeds the engine and absorbs its writes; a reference
// model computes every cell's expected writes and the destination image
// directly from the streaming/bounce-back rules.
`timescale 1ns/1ps

module tb_lbm_stream_engine;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int ND = 9;

  localparam int MDX  [ND] = '{0, 0, 1, 1, 1, 0, -1, -1, -1};
  localparam int MDY  [ND] = '{0, -1, -1, 0, 1, 1, 1, 0, -1};
  localparam int MOPP [ND] = '{0, 5, 6, 7, 8, 1, 2, 3, 4};

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_i = 1'b0;
  logic              busy, done, bank_sel;
  logic [31:0]       step;
  logic [AW-1:0]     rd_addr;
  logic [ND*DW-1:0]  rd_data;
  logic              rd_barrier;
  logic [ND-1:0]     wr_en;
  logic [ND*AW-1:0]  wr_addr;
  logic [ND*DW-1:0]  wr_data;

  always #5 clk = ~clk;

  lbm_stream_engine #(.GRID_W(W), .GRID_H(H), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .busy_o       (busy),
    .done_o       (done),
    .bank_sel_o   (bank_sel),
    .step_count_o (step),
    .rd_addr_o    (rd_addr),
    .rd_data_i    (rd_data),
    .rd_barrier_i (rd_barrier),
    .wr_en_o      (wr_en),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data)
  );

  // Bench RAM: two population buffers, barrier map, image loader.
  logic [DW-1:0] mem [2][ND][N];
  logic [DW-1:0] img [2][ND][N];
  logic          bar [N];
  logic          load_req = 1'b0;

  always @(posedge clk) begin
    if (load_req) begin
      mem <= img;
    end else begin
      for (int k = 0; k < ND; k++)
        if (wr_en[k]) mem[bank_sel ? 0 : 1][k][wr_addr[k*AW +: AW]] <= wr_data[k*DW +: DW];
    end
    for (int k = 0; k < ND; k++) rd_data[k*DW +: DW] <= mem[bank_sel][k][rd_addr];
    rd_barrier <= bar[rd_addr];
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int              mbank = 0;
  int unsigned     mstep = 0;
  logic [ND-1:0]   exp_en   [N];
  int              exp_addr [N][ND];
  logic [DW-1:0]   exp_data [N][ND];
  logic [DW-1:0]   nimg     [ND][N];

  task automatic compute_expected();
    int x, y, nx, ny;
    logic inb;
    logic [DW-1:0] d;
    for (int k = 0; k < ND; k++)
      for (int c = 0; c < N; c++) nimg[k][c] = img[1 - mbank][k][c];
    for (int c = 0; c < N; c++) begin
      x = c % W;
      y = c / W;
      for (int k = 0; k < ND; k++) begin
        nx = x + MDX[k];
        ny = y + MDY[k];
`ifdef PERIODIC_X_EN
        if (nx < 0) nx = nx + W;
        else if (nx >= W) nx = nx - W;
`endif
        inb = (nx >= 0) && (nx < W) && (ny >= 0) && (ny < H);
        d = bar[c] ? img[mbank][MOPP[k]][c] : img[mbank][k][c];
        exp_en[c][k]   = inb;
        exp_addr[c][k] = ny * W + nx;
        exp_data[c][k] = d;
        if (inb) nimg[k][ny * W + nx] = d;
      end
    end
  endtask

  // ---------------- per-cycle compare process ----------------
  event pass_started;

  initial begin
    forever begin
      @(pass_started);
      for (int e = 0; e <= N + 2; e++) begin
        @(negedge clk);
        chk($sformatf("busy e=%0d", e), busy, (e <= N + 1));
        chk($sformatf("done e=%0d", e), done, (e == N + 2));
        if (e >= 2 && e <= N + 1) begin
          chk($sformatf("wr_en cell=%0d", e - 2), wr_en, exp_en[e - 2]);
          for (int k = 0; k < ND; k++) begin
            if (exp_en[e - 2][k]) begin
              chk($sformatf("wr_addr cell=%0d dir=%0d", e - 2, k),
                  wr_addr[k*AW +: AW], exp_addr[e - 2][k]);
              chk($sformatf("wr_data cell=%0d dir=%0d", e - 2, k),
                  wr_data[k*DW +: DW], exp_data[e - 2][k]);
            end
          end
        end else begin
          chk($sformatf("wr_en quiet e=%0d", e), wr_en, 0);
        end
        if (e < N + 2) @(posedge clk);
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic clear_all();
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < ND; k++)
        for (int c = 0; c < N; c++) img[b][k][c] = '0;
    for (int c = 0; c < N; c++) bar[c] = 1'b0;
  endtask

  task automatic push_image();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  // Run one pass; extra >= 0 pulses start again at that cycle of the pass.
  task automatic run_pass(input int extra, output int lat);
    int dst;
    bit got;
    got = 1'b0;
    compute_expected();
    @(negedge clk);
    start_i = 1'b1;
    @(posedge clk);
    -> pass_started;
    lat = 1;
    for (int g = 0; g < 200; g++) begin
      @(negedge clk);
      start_i = ((lat - 1) == extra);
      if (done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    start_i = 1'b0;
    if (!got) chk("done timeout", 0, 1);
    dst = 1 - mbank;
    for (int k = 0; k < ND; k++)
      for (int c = 0; c < N; c++) img[dst][k][c] = nimg[k][c];
    mbank = dst;
    mstep++;
    chk("bank_sel after pass", bank_sel, mbank);
    chk("step_count after pass", step, mstep);
    for (int k = 0; k < ND; k++)
      for (int c = 0; c < N; c++)
        chk($sformatf("image bank=%0d dir=%0d cell=%0d", dst, k, c), mem[dst][k][c], img[dst][k][c]);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int cnt;
    clear_all();
    load_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    load_req = 1'b0;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset wr_en", wr_en, 0);
    chk("reset bank_sel", bank_sel, 0);
    chk("reset step_count", step, 0);
    chk("reset rd_addr", rd_addr, 0);
    chk("reset wr_addr", wr_addr, 0);
    chk("reset wr_data", wr_data, 0);
    @(negedge clk);
    rst = 1'b0;

    // Fluid stream: E at (1,1) moves to (2,1).
    img[0][3][5] = 16'h0100;
    push_image();
    run_pass(-1, lat);
    chk("latency start->done", lat, 19);
    chk("fluid E at (2,1)", mem[1][3][6], 16'h0100);
    chk("fluid bank_sel", bank_sel, 1);
    chk("fluid step_count", step, 1);

    // Second pass: E continues to (3,1) in bank 0.
    run_pass(-1, lat);
    chk("pass2 E at (3,1)", mem[0][3][7], 16'h0100);
    chk("pass2 bank_sel", bank_sel, 0);
    chk("pass2 step_count", step, 2);

    // Bounce-back: barrier at (2,1) sends E back as W to (1,1).
    clear_all();
    bar[6] = 1'b1;
    img[0][3][6] = 16'd5;
    push_image();
    run_pass(-1, lat);
    chk("bounce W at (1,1)", mem[1][7][5], 16'd5);
    chk("bounce no E at (3,1)", mem[1][3][7], 16'd0);
    bar[6] = 1'b0;

    // Edge: E at (3,1) leaves east; NE at (3,0) leaves the top.
    clear_all();
    img[1][3][7] = 16'd7;
    img[1][2][3] = 16'd9;
    img[0][3][4] = 16'hAAAA;
    push_image();
    run_pass(-1, lat);
`ifdef PERIODIC_X_EN
    chk("edge E wraps to (0,1)", mem[0][3][4], 16'd7);
`else
    chk("edge E inflow untouched", mem[0][3][4], 16'hAAAA);
`endif
    cnt = 0;
    for (int c = 0; c < N; c++) if (mem[0][2][c] == 16'd9) cnt++;
    chk("edge NE dropped", cnt, 0);

    // Rest populations stay in place.
    clear_all();
    for (int c = 0; c < N; c++) img[0][0][c] = 16'h0055;
    push_image();
    run_pass(-1, lat);
    for (int c = 0; c < N; c++) chk($sformatf("rest C0 cell=%0d", c), mem[1][0][c], 16'h0055);

    // Start pulse during RUN is ignored.
    run_pass(5, lat);
    repeat (4) @(negedge clk);
    chk("ignored start busy", busy, 0);
    chk("ignored start step_count", step, 6);

    // Asynchronous reset in the middle of a pass.
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    chk("midpass busy before rst", busy, 1);
    rst = 1'b1;
    #1;
    chk("midpass rst busy", busy, 0);
    chk("midpass rst wr_en", wr_en, 0);
    chk("midpass rst bank_sel", bank_sel, 0);
    chk("midpass rst step_count", step, 0);
    chk("midpass rst done", done, 0);
    chk("midpass rst rd_addr", rd_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
